// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles framed serial bits into WIDTH-bit words
// with selectable bit order, mid-frame resync, inter-bit gap timeout and sticky error flags.
module sipo_deser #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             ovf_err,
  output logic             sync_err,
  output logic             tmo_err,
  input  logic             clr_err
);

  localparam int unsigned GapW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GapW-1:0] GapLast = (TIMEOUT == 0) ? '0 : GapW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             order_q, order_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             sync_q, sync_d;
  logic             tmo_q, tmo_d;

  logic             out_free;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] frame_first;

  // Next-state logic for the frame FSM, the output holding register and the sticky flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    order_d = order_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q & ~clr_err;
    sync_d  = sync_q & ~clr_err;
    tmo_d   = tmo_q & ~clr_err;

    out_free = !valid_q || m_ready;
    if (valid_q && m_ready) valid_d = 1'b0;

    // LSB-first shifts right so bit 0 ends at index 0; MSB-first shifts left so bit 0 ends on top.
    shifted     = order_q ? {s_data, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], s_data};
    frame_first = lsb_first ? {s_data, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_data};

    case (state_q)
      StIdle: begin
        if (s_valid && s_start) begin
          state_d = StShift;
          cnt_d   = CNT_W'(1);
          sr_d    = frame_first;
          order_d = lsb_first;
          gap_d   = '0;
        end
      end
      StShift: begin
        if (s_valid && s_start) begin
          // Resync: this bit restarts the frame.
          sync_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          sr_d    = frame_first;
          order_d = lsb_first;
          gap_d   = '0;
        end else if (s_valid) begin
          gap_d = '0;
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (out_free) begin
              data_d  = shifted;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (TIMEOUT != 0) begin
          if (gap_q == GapLast) begin
            state_d = StIdle;
            cnt_d   = '0;
            gap_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      order_q <= 1'b0;
      gap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      sync_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      order_q <= order_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      sync_q  <= sync_d;
      tmo_q   <= tmo_d;
    end
  end

  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign bit_cnt  = cnt_q;
  assign busy     = (state_q == StShift);
  assign ovf_err  = ovf_q;
  assign sync_err = sync_q;
  assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed and random serial traffic, checked against a frame-level
// queue model by a negedge monitor.
module tb_sipo_deser;
  localparam int W   = 3;
  localparam int TMO = 4;
  localparam int CW  = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_data = 1'b0, s_start = 1'b0, lsb_first = 1'b0;
  logic          m_ready = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_valid, busy, ovf_err, sync_err, tmo_err;
  logic [CW-1:0] bit_cnt;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
    .lsb_first(lsb_first), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .bit_cnt(bit_cnt), .busy(busy), .ovf_err(ovf_err), .sync_err(sync_err),
    .tmo_err(tmo_err), .clr_err(clr_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame bits kept as a list, word built arithmetically on completion.
  bit frame[$];
  bit in_frame = 0;
  bit ord = 0;
  int gap = 0;
  int exp_q[$];
  int exp_data = 0;
  bit e_ovf = 0, e_sync = 0, e_tmo = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int assemble(input bit lsb);
    int w = 0;
    for (int k = 0; k < W; k++)
      if (frame[k]) w += lsb ? (1 << k) : (1 << (W - 1 - k));
    return w;
  endfunction

  task automatic model_step();
    bit ev_ovf = 0, ev_sync = 0, ev_tmo = 0;
    int word;
    if (!rst_n) begin
      frame.delete(); in_frame = 0; gap = 0; exp_q.delete(); exp_data = 0;
      e_ovf = 0; e_sync = 0; e_tmo = 0;
      return;
    end
    if (s_valid && s_start) begin
      if (in_frame) ev_sync = 1;
      frame.delete(); frame.push_back(s_data);
      ord = lsb_first; in_frame = 1; gap = 0;
    end else if (in_frame && s_valid) begin
      frame.push_back(s_data); gap = 0;
      if (frame.size() == W) begin
        word = assemble(ord);
        // exp_q is already empty if the held word is being taken this cycle.
        if (exp_q.size() == 0) begin
          exp_q.push_back(word); exp_data = word;
        end else ev_ovf = 1;
        frame.delete(); in_frame = 0;
      end
    end else if (in_frame) begin
      gap++;
      if (gap == TMO) begin
        ev_tmo = 1; in_frame = 0; frame.delete(); gap = 0;
      end
    end
    e_ovf  = (e_ovf && !clr_err) || ev_ovf;
    e_sync = (e_sync && !clr_err) || ev_sync;
    e_tmo  = (e_tmo && !clr_err) || ev_tmo;
  endtask

  // Monitor: compares visible state each negedge; pops the scoreboard when the word is taken.
  always @(negedge clk) begin
    chk("m_valid", int'(m_valid), int'(exp_q.size() != 0));
    chk("m_data", int'(m_data), exp_data);
    chk("bit_cnt", int'(bit_cnt), in_frame ? frame.size() : 0);
    chk("busy", int'(busy), int'(in_frame));
    chk("ovf_err", int'(ovf_err), int'(e_ovf));
    chk("sync_err", int'(sync_err), int'(e_sync));
    chk("tmo_err", int'(tmo_err), int'(e_tmo));
    if (exp_q.size() != 0 && m_ready) begin
      chk("word", int'(m_data), exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input bit v, input bit d, input bit st, input bit l, input bit r,
                     input bit c, input bit rn);
    #1;
    s_valid = v; s_data = d; s_start = st; lsb_first = l; m_ready = r; clr_err = c; rst_n = rn;
    @(posedge clk);
    model_step();
  endtask

  task automatic send_word(input int word, input bit l, input bit r);
    for (int k = 0; k < W; k++)
      cyc(1, l ? word[k] : word[W - 1 - k], k == 0, l, r, 0, 1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, r, 0, 1);
  endtask

  initial begin
    int words[5] = '{5, 0, 3, 7, 1};
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Back-to-back MSB-first frames.
    foreach (words[i]) send_word(words[i], 0, 1);
    idle(2, 1);
    // Bit order: 1,0,0 LSB-first then MSB-first; then order toggled mid-frame.
    cyc(1, 1, 1, 1, 1, 0, 1); cyc(1, 0, 0, 1, 1, 0, 1); cyc(1, 0, 0, 1, 1, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 1); cyc(1, 0, 0, 0, 1, 0, 1); cyc(1, 0, 0, 0, 1, 0, 1);
    cyc(1, 1, 1, 1, 1, 0, 1); cyc(1, 0, 0, 0, 1, 0, 1); cyc(1, 0, 0, 0, 1, 0, 1);
    // Ignored bit in idle.
    cyc(1, 1, 0, 0, 1, 0, 1);
    idle(1, 1);
    // Overflow with consumer stalled.
    send_word(6, 0, 0); send_word(2, 0, 0);
    idle(2, 0);
    idle(2, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    idle(1, 1);
    // Resync: two bits, then a new start.
    cyc(1, 0, 1, 0, 1, 0, 1); cyc(1, 1, 0, 0, 1, 0, 1);
    cyc(1, 1, 1, 0, 1, 0, 1); cyc(1, 1, 0, 0, 1, 0, 1); cyc(1, 1, 0, 0, 1, 0, 1);
    idle(1, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    // Gap timeout, then the next bit arriving just before it would fire.
    cyc(1, 1, 1, 0, 1, 0, 1); idle(TMO, 1); idle(1, 1);
    cyc(1, 1, 1, 0, 1, 0, 1); idle(TMO - 1, 1);
    cyc(1, 0, 0, 0, 1, 0, 1); idle(TMO - 1, 1);
    cyc(1, 1, 0, 0, 1, 0, 1); idle(2, 1);
    // Clear and a set event in the same cycle: flag must stay set.
    cyc(1, 1, 1, 0, 1, 0, 1); cyc(1, 0, 1, 0, 1, 1, 1);
    idle(TMO + 1, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    // Reset mid-frame with a held word.
    send_word(3, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(1, 1);
    send_word(5, 0, 1);
    idle(2, 1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(9) < 7), $urandom_range(1), ($urandom_range(9) < 2),
          $urandom_range(1), ($urandom_range(9) < 7), ($urandom_range(29) == 0),
          ($urandom_range(199) != 0));
      if ($urandom_range(19) == 0) idle($urandom_range(TMO + 1), $urandom_range(1));
    end
    idle(3, 1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer. It is the sequential successor to the team's 3-bit value-to-bit-lines mux.
- Assembles a framed serial bit stream into WIDTH-bit words and presents each word on a registered parallel bus. Handshake is valid/ready.
- Has selectable bit order, frame resync, inter-bit gap timeout and sticky error flags.
- Sits between a serial front end (pin sampler or bit generator) and parallel consumer logic.

Parameters:
- WIDTH, 3: bits per word; legal range 2..32.
- TIMEOUT, 16: max idle cycles between accepted bits inside a frame; 0 disables the timeout.
- CNT_W, $clog2(WIDTH+1): width of the bit counter; derived, do not override.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  serial bit present this cycle.
- s_data  in  1  serial bit value.
- s_start  in  1  first bit of a frame; qualified by s_valid.
- lsb_first  in  1  bit order for the frame; 1 = first bit goes to m_data[0].
- m_data  out  WIDTH  assembled word, registered.
- m_valid  out  1  m_data holds an unconsumed word.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- bit_cnt  out  CNT_W  bits collected in the current frame.
- busy  out  1  frame in progress (state SHIFT).
- ovf_err  out  1  sticky: completed word dropped because the output was full.
- sync_err  out  1  sticky: s_start arrived mid-frame.
- tmo_err  out  1  sticky: gap timeout aborted a frame.
- clr_err  in  1  one-cycle pulse clears all sticky flags.

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - state=IDLE.
  - m_data=0, m_valid=0, bit_cnt=0, busy=0, all error flags 0.
  - Internal shift register and gap counter cleared.
  - Reset mid-frame discards the partial word and any held output word.
- States are IDLE and SHIFT.
- IDLE:
  - s_valid && !s_start: bit ignored, no flag.
  - s_valid && s_start: latch lsb_first into the frame order bit, store s_data as bit 0 of the frame, bit_cnt=1, go to SHIFT.
- SHIFT:
  - Each s_valid cycle stores s_data as the next bit and increments bit_cnt.
  - MSB-first order: frame bit k lands in m_data[WIDTH-1-k].
  - LSB-first order: frame bit k lands in m_data[k].
  - lsb_first changes during a frame have no effect.
- Word completion: the cycle bit WIDTH-1 is accepted.
  - If the output is free (m_valid=0, or m_valid && m_ready in the same cycle), m_data is loaded and m_valid=1 on the next cycle. Latency is one cycle from the last bit to m_valid.
  - Otherwise the new word is dropped, ovf_err is set, and m_data/m_valid are unchanged.
  - In both cases: bit_cnt=0, state goes to IDLE.
- Back-to-back frames: the first bit of the next frame (s_valid && s_start) may arrive the cycle after completion. No dead cycles are required.
- Resync: s_valid && s_start in SHIFT.
  - Partial word discarded, sync_err set.
  - That bit becomes bit 0 of a new frame: bit_cnt=1, order re-latched.
- Gap timeout (TIMEOUT>0):
  - The gap counter counts consecutive SHIFT cycles with s_valid=0 and resets on each accepted bit.
  - On reaching TIMEOUT: frame aborted, tmo_err set, bit_cnt=0, state goes to IDLE.
  - s_valid arriving in the same cycle the counter would hit TIMEOUT is accepted; no timeout occurs.
- Output handshake:
  - m_valid stays high and m_data stays stable until m_valid && m_ready.
  - Then m_valid=0 next cycle, unless a word completes in that same cycle.
  - m_ready while m_valid=0 is ignored.
- Sticky flags:
  - Set by their event and held until clr_err.
  - If clr_err and a set event occur in the same cycle, the flag ends up set.
- busy = (state==SHIFT).
- bit_cnt never exceeds WIDTH-1 as a visible value.

Test Plan:
- WIDTH=3, MSB-first, m_ready=1. Frames 5, 0, 3, 7, 1, each sent back-to-back as 3 bits with s_start on the first -> m_data=5,0,3,7,1 in order. Each m_valid pulse comes 1 cycle after the last bit. No error flags.
- WIDTH=3, lsb_first=1, serial bits 1,0,0 -> m_data=1. Same bits MSB-first -> m_data=4. Toggle lsb_first mid-frame -> order unchanged.
- m_ready=0. Send frames 6 then 2 -> m_data stays 6, ovf_err=1. Raise m_ready -> m_valid drops next cycle. clr_err -> ovf_err=0.
- Send 2 bits, then s_start with bit 1, then bits 1,1 -> sync_err=1, m_data=7.
- TIMEOUT=4. Send 1 bit, then hold s_valid=0 for 4 cycles -> tmo_err=1, busy=0, no m_valid. Repeat with the next bit arriving on gap cycle 4 -> no timeout.
- Assert rst_n=0 for 1 cycle mid-frame and with m_valid=1 -> all outputs 0. Next full frame 5 -> m_data=5.
